// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_pkg : shared constants and types for the pipelined arbiter    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pipe_pkg;
  localparam int W_DEF = 10;
  localparam int NREQ  = 4;
  localparam int LAT   = 3;

  typedef logic [1:0] id_t;
endpackage
`default_nettype wire

// File: rtl/pipe_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_core : 3-stage F=((A+B)+(C-D))*D datapath with valid/id band  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pipe_core
  import pipe_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_hold,
  input  logic         i_valid,
  input  id_t          i_id,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  input  logic [W-1:0] i_d,
  output logic         o_valid,
  output id_t          o_id,
  output logic [W-1:0] o_f,
  output logic [1:0]   o_inflight
);

  logic         r_v1, r_v2, r_v3;
  id_t          r_id1, r_id2, r_id3;
  logic [W-1:0] r_x1, r_x2, r_d1;
  logic [W-1:0] r_x3, r_d2;
  logic [W-1:0] r_f;
  logic [W-1:0] w_prod;

  // Product truncated to W bits by the assignment context.
  assign w_prod = r_x3 * r_d2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_id1 <= '0;
      r_id2 <= '0;
      r_id3 <= '0;
      r_x1  <= '0;
      r_x2  <= '0;
      r_d1  <= '0;
      r_x3  <= '0;
      r_d2  <= '0;
      r_f   <= '0;
    end else if (!i_hold) begin
      r_v1  <= i_valid;
      r_id1 <= i_id;
      r_x1  <= i_a + i_b;
      r_x2  <= i_c - i_d;
      r_d1  <= i_d;

      r_v2  <= r_v1;
      r_id2 <= r_id1;
      r_x3  <= r_x1 + r_x2;
      r_d2  <= r_d1;

      r_v3  <= r_v2;
      // Result fields only refresh on a valid op so they hold across bubbles.
      if (r_v2) begin
        r_id3 <= r_id2;
        r_f   <= w_prod;
      end
    end
  end

  assign o_valid    = r_v3;
  assign o_id       = r_id3;
  assign o_f        = r_f;
  assign o_inflight = {1'b0, r_v1} + {1'b0, r_v2} + {1'b0, r_v3};

endmodule
`default_nettype wire

// File: rtl/pipe_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_arbiter : 4-way round-robin issue into a stallable pipeline   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pipe_arbiter
  import pipe_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  input  logic [NREQ*W-1:0] op_c,
  input  logic [NREQ*W-1:0] op_d,
  output logic [NREQ-1:0]   gnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_f,
  output id_t               out_id,
  output logic [1:0]        inflight
);

  id_t             r_ptr;
  id_t             w_idx;
  id_t             w_cand;
  logic            w_found;
  logic            w_stall;
  logic [NREQ-1:0] w_gnt;
  logic [W-1:0]    w_a, w_b, w_c, w_d;

  assign w_stall = out_valid & ~out_ready;

  // Search starts one past the last granted requester.
  always_comb begin
    w_gnt   = '0;
    w_idx   = r_ptr;
    w_cand  = r_ptr;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = r_ptr + id_t'(k);
      if (!w_found && req[w_cand] && !rst && !w_stall) begin
        w_gnt[w_cand] = 1'b1;
        w_idx         = w_cand;
        w_found       = 1'b1;
      end
    end
  end

  always_comb begin
    w_a = op_a[W-1:0];
    w_b = op_b[W-1:0];
    w_c = op_c[W-1:0];
    w_d = op_d[W-1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (w_idx == id_t'(i)) begin
        w_a = op_a[i*W +: W];
        w_b = op_b[i*W +: W];
        w_c = op_c[i*W +: W];
        w_d = op_d[i*W +: W];
      end
    end
  end

  // Pointer reset to 3 gives requester 0 first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= id_t'(NREQ - 1);
    end else if (w_found) begin
      r_ptr <= w_idx;
    end
  end

  pipe_core #(.W(W)) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_hold     (w_stall),
    .i_valid    (w_found),
    .i_id       (w_idx),
    .i_a        (w_a),
    .i_b        (w_b),
    .i_c        (w_c),
    .i_d        (w_d),
    .o_valid    (out_valid),
    .o_id       (out_id),
    .o_f        (out_f),
    .o_inflight (inflight)
  );

  assign gnt = w_gnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_arbiter : directed self-checking bench for pipe_arbiter    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pipe_arbiter;
  localparam int W = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3:0]     req = '0;
  logic [4*W-1:0] op_a = '0, op_b = '0, op_c = '0, op_d = '0;
  logic [3:0]     gnt;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out_f;
  logic [1:0]     out_id;
  logic [1:0]     inflight;

  int checks = 0;
  int passes = 0;

  pipe_arbiter #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_c      (op_c),
    .op_d      (op_d),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_f     (out_f),
    .out_id    (out_id),
    .inflight  (inflight)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, b, c, d);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
    op_c[i*W +: W] = c;
    op_d[i*W +: W] = d;
  endtask

  task automatic test_reset();
    req = 4'b1111;
    #1;
    checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got=%b exp=0000", gnt); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (out_f !== '0) $display("FAIL reset_f got=%0d exp=0", out_f); else passes++;
    checks++; if (out_id !== 2'd0) $display("FAIL reset_id got=%0d exp=0", out_id); else passes++;
    checks++; if (inflight !== 2'd0) $display("FAIL reset_inflight got=%0d exp=0", inflight); else passes++;
    req = '0;
    step();
    rst = 1'b0;
    step();
  endtask

  // (3+4+10-2)*2 = 30
  task automatic test_single();
    set_ops(0, 3, 4, 10, 2);
    req = 4'b0001;
    #1;
    checks++; if (gnt !== 4'b0001) $display("FAIL single_gnt got=%b exp=0001", gnt); else passes++;
    step();
    req = '0;
    checks++; if (out_valid !== 1'b0 || inflight !== 2'd1) $display("FAIL single_e1 got v=%b n=%0d exp v=0 n=1", out_valid, inflight); else passes++;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL single_e2 got=%b exp=0", out_valid); else passes++;
    step();
    checks++; if (out_valid !== 1'b1 || out_f !== 10'd30 || out_id !== 2'd0)
      $display("FAIL single_out got v=%b f=%0d id=%0d exp v=1 f=30 id=0", out_valid, out_f, out_id); else passes++;
    step();
    checks++; if (out_valid !== 1'b0 || inflight !== 2'd0) $display("FAIL single_drain got v=%b n=%0d exp 0 0", out_valid, inflight); else passes++;
  endtask

  // Pointer is 0 here: req 0100 wins as 2, then req 0010 searched from 3 wins as 1.
  task automatic test_wrap();
    set_ops(2, 1000, 100, 0, 1);
    set_ops(1, 300, 300, 2, 2);
    req = 4'b0100;
    #1;
    checks++; if (gnt !== 4'b0100) $display("FAIL wrap_gnt2 got=%b exp=0100", gnt); else passes++;
    step();
    req = 4'b0010;
    #1;
    checks++; if (gnt !== 4'b0010) $display("FAIL wrap_gnt1 got=%b exp=0010", gnt); else passes++;
    step();
    req = '0;
    step();
    checks++; if (out_valid !== 1'b1 || out_f !== 10'd75 || out_id !== 2'd2)
      $display("FAIL wrap_a got v=%b f=%0d id=%0d exp v=1 f=75 id=2", out_valid, out_f, out_id); else passes++;
    step();
    checks++; if (out_valid !== 1'b1 || out_f !== 10'd176 || out_id !== 2'd1)
      $display("FAIL wrap_b got v=%b f=%0d id=%0d exp v=1 f=176 id=1", out_valid, out_f, out_id); else passes++;
    step();
  endtask

  // Requester i: A=10+i, B=i, C=5, D=2 -> F = (13+2i)*2 = 26+4i
  task automatic load_rr_ops();
    for (int i = 0; i < 4; i++) set_ops(i, 10'(10 + i), 10'(i), 10'd5, 10'd2);
  endtask

  task automatic test_round_robin();
    int errs;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    load_rr_ops();
    req = 4'b1111;
    errs = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      checks++; if (gnt !== 4'(1 << (k % 4))) $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, gnt, 4'(1 << (k % 4))); else passes++;
      step();
      if (k >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'((k - 2) % 4) || out_f !== 10'(26 + 4 * ((k - 2) % 4)) || inflight !== 2'd3)
          $display("FAIL rr_out k=%0d got v=%b id=%0d f=%0d n=%0d exp v=1 id=%0d f=%0d n=3",
                   k, out_valid, out_id, out_f, inflight, (k - 2) % 4, 26 + 4 * ((k - 2) % 4));
        else passes++;
      end
    end
    req = '0;
    step(); step(); step();
    checks++; if (inflight !== 2'd0) $display("FAIL rr_drain got=%0d exp=0", inflight); else passes++;
  endtask

  // Pointer is 3 here: grants 0,1,2, then stall with op0 at the output.
  task automatic test_stall();
    req = 4'b1111;
    step(); step(); step();
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_f !== 10'd26)
      $display("FAIL stall_head got v=%b id=%0d f=%0d exp v=1 id=0 f=26", out_valid, out_id, out_f); else passes++;
    for (int k = 0; k < 5; k++) begin
      checks++; if (gnt !== 4'b0000) $display("FAIL stall_gnt k=%0d got=%b exp=0000", k, gnt); else passes++;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'd0 || out_f !== 10'd26 || inflight !== 2'd3)
        $display("FAIL stall_hold k=%0d got v=%b id=%0d f=%0d n=%0d exp v=1 id=0 f=26 n=3", k, out_valid, out_id, out_f, inflight);
      else passes++;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (gnt !== 4'b1000) $display("FAIL stall_resume_gnt got=%b exp=1000", gnt); else passes++;
    step();
    req = '0;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'(k) || out_f !== 10'(26 + 4 * k))
        $display("FAIL stall_order k=%0d got v=%b id=%0d f=%0d exp v=1 id=%0d f=%0d", k, out_valid, out_id, out_f, k, 26 + 4 * k);
      else passes++;
      step();
    end
    checks++; if (out_valid !== 1'b0) $display("FAIL stall_empty got=%b exp=0", out_valid); else passes++;
  endtask

  task automatic test_mid_reset();
    req = 4'b1111;
    step(); step(); step();
    checks++; if (inflight !== 2'd3) $display("FAIL mrst_pre got=%0d exp=3", inflight); else passes++;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || inflight !== 2'd0 || gnt !== 4'b0000)
      $display("FAIL mrst_now got v=%b n=%0d g=%b exp 0 0 0000", out_valid, inflight, gnt); else passes++;
    step();
    rst = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0001) $display("FAIL mrst_first_gnt got=%b exp=0001", gnt); else passes++;
    step();
    req = '0;
    checks++; if (out_valid !== 1'b0) $display("FAIL mrst_stale1 got=%b exp=0", out_valid); else passes++;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL mrst_stale2 got=%b exp=0", out_valid); else passes++;
    step();
    checks++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_f !== 10'd26)
      $display("FAIL mrst_new got v=%b id=%0d f=%0d exp v=1 id=0 f=26", out_valid, out_id, out_f); else passes++;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_stall();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
